// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and divisor limits shared by the UART RX/TX blocks
package uart_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} rx_state_t;
    localparam int MIN_DIV = 4;
endpackage

// File: rtl/rx_div_reg.sv
// rx_div_reg: bit-period divisor register with load validation and error strobe
module rx_div_reg
    import uart_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter logic [DIV_W-1:0] RST_DIV = 16'd5208
) (
    input  logic             CLK,
    input  logic             Rst,
    input  logic             Div_Load,
    input  logic [DIV_W-1:0] Div_Val,
    input  logic             Load_Ok,
    output logic [DIV_W-1:0] Div_Reg,
    output logic             Div_Err
);
    logic accept;
    assign accept = Load_Ok && Div_Val >= DIV_W'(MIN_DIV);
    always_ff @(posedge CLK) begin
        if (Rst) begin
            Div_Reg <= RST_DIV;
            Div_Err <= 1'b0;
        end else begin
            Div_Err <= Div_Load && !accept;
            if (Div_Load && accept) Div_Reg <= Div_Val;
        end
    end
endmodule

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: per-bit timing of an RX frame with mid-bit sample and bit-end strobes
module rx_bit_timer
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600,
    parameter int DIV_W  = 16
) (
    input  logic             CLK,
    input  logic             Rst,
    input  logic             Count_Sig,
    input  logic [3:0]       Frame_Bits,
    input  logic             Div_Load,
    input  logic [DIV_W-1:0] Div_Val,
    output logic             Sample_Tick,
    output logic             Bit_End,
    output logic [3:0]       Bit_Idx,
    output logic             Frame_Done,
    output logic             Busy,
    output logic             Div_Err
);
    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(CLK_HZ / BAUD);
    rx_state_t        state;
    logic             prev, run, start, load_ok;
    logic [DIV_W-1:0] cnt, div_reg;
    logic [3:0]       fbits;
    assign run         = state == RUN;
    assign start       = state == IDLE && Count_Sig && !prev;
    assign load_ok     = (state == IDLE && !start) || state == HOLD;
    assign Busy        = run;
    assign Sample_Tick = run && cnt == (div_reg >> 1);
    assign Bit_End     = run && cnt == div_reg - DIV_W'(1);
    assign Frame_Done  = Bit_End && Bit_Idx == fbits - 4'd1;
    rx_div_reg #(.DIV_W(DIV_W), .RST_DIV(RST_DIV)) u_div (
        .CLK(CLK), .Rst(Rst), .Div_Load(Div_Load), .Div_Val(Div_Val),
        .Load_Ok(load_ok), .Div_Reg(div_reg), .Div_Err(Div_Err)
    );
    always_ff @(posedge CLK) begin
        if (Rst) begin
            state   <= IDLE;
            prev    <= 1'b0;
            cnt     <= '0;
            Bit_Idx <= '0;
            fbits   <= 4'd2;
        end else begin
            prev <= Count_Sig;
            case (state)
                IDLE: if (start) begin
                    state   <= RUN;
                    cnt     <= '0;
                    Bit_Idx <= '0;
                    fbits   <= Frame_Bits < 4'd2 ? 4'd2 : Frame_Bits;
                end
                RUN: if (!Count_Sig || Frame_Done) begin
                    state   <= Count_Sig ? HOLD : IDLE;
                    cnt     <= '0;
                    Bit_Idx <= '0;
                end else if (Bit_End) begin
                    cnt     <= '0;
                    Bit_Idx <= Bit_Idx + 4'd1;
                end else begin
                    cnt <= cnt + DIV_W'(1);
                end
                HOLD: if (!Count_Sig) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rx_bit_timer.sv
// tb_rx_bit_timer: directed and random stimulus against a time-since-frame-start reference model
module tb_rx_bit_timer;
    localparam int DEF_DIV = 50_000_000 / 9600;
    logic        CLK = 1'b0, Rst = 1'b1, Count_Sig = 1'b0, Div_Load = 1'b0;
    logic [3:0]  Frame_Bits = '0;
    logic [15:0] Div_Val = '0;
    logic        Sample_Tick, Bit_End, Frame_Done, Busy, Div_Err;
    logic [3:0]  Bit_Idx;
    int n_assert = 0, n_fail = 0;
    int m_mode = 0, m_t = 0, m_div = DEF_DIV, m_bits = 2;
    bit m_prev = 1'b0, m_err = 1'b0;
    int st_cnt = 0, fd_t = -1;
    always #5 CLK = ~CLK;
    rx_bit_timer dut (
        .CLK(CLK), .Rst(Rst), .Count_Sig(Count_Sig), .Frame_Bits(Frame_Bits),
        .Div_Load(Div_Load), .Div_Val(Div_Val), .Sample_Tick(Sample_Tick),
        .Bit_End(Bit_End), .Bit_Idx(Bit_Idx), .Frame_Done(Frame_Done),
        .Busy(Busy), .Div_Err(Div_Err)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    // Model: mode 0 idle, 1 run, 2 hold; in run, position is t cycles since frame start
    task automatic step(input bit cs, input bit ld, input int dv, input int fb, input bit rst);
        bit run, be, fd, st, start, ok;
        int c, b;
        Count_Sig = cs; Div_Load = ld; Div_Val = 16'(dv); Frame_Bits = 4'(fb); Rst = rst;
        run = m_mode == 1;
        c = m_t % m_div;
        b = m_t / m_div;
        st = run && c == m_div / 2;
        be = run && c == m_div - 1;
        fd = be && b == m_bits - 1;
        chk("sample_tick", {31'd0, Sample_Tick}, {31'd0, st});
        chk("bit_end", {31'd0, Bit_End}, {31'd0, be});
        chk("frame_done", {31'd0, Frame_Done}, {31'd0, fd});
        chk("busy", {31'd0, Busy}, {31'd0, run});
        chk("bit_idx", {28'd0, Bit_Idx}, run ? b : 0);
        chk("div_err", {31'd0, Div_Err}, {31'd0, m_err});
        if (Sample_Tick === 1'b1) st_cnt++;
        if (Frame_Done === 1'b1) fd_t = m_t;
        @(posedge CLK);
        if (rst) begin
            m_mode = 0; m_t = 0; m_div = DEF_DIV; m_prev = 1'b0; m_err = 1'b0;
        end else begin
            start = m_mode == 0 && cs && !m_prev;
            ok = ((m_mode == 0 && !start) || m_mode == 2) && dv >= 4;
            m_err = ld && !ok;
            if (ld && ok) m_div = dv;
            case (m_mode)
                0: if (start) begin m_mode = 1; m_t = 0; m_bits = fb < 2 ? 2 : fb; end
                1: if (!cs) m_mode = 0; else if (fd) m_mode = 2; else m_t++;
                2: if (!cs) m_mode = 0;
                default: m_mode = 0;
            endcase
            m_prev = cs;
        end
        @(negedge CLK);
    endtask
    initial begin
        bit cs;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        step(0, 0, 0, 0, 1);
        step(0, 1, 10, 0, 0);
        st_cnt = 0; fd_t = -1;
        step(1, 0, 0, 10, 0);
        repeat (110) step(1, 0, 0, 10, 0);
        chk("frame1_ticks", st_cnt, 10);
        chk("frame1_done_t", fd_t, 99);
        repeat (3) step(0, 0, 0, 10, 0);
        step(1, 0, 0, 10, 0);
        repeat (34) step(1, 0, 0, 10, 0);
        fd_t = -1;
        step(0, 0, 0, 10, 0);
        repeat (3) step(0, 0, 0, 10, 0);
        chk("abort_no_done", fd_t, -1);
        step(1, 0, 0, 10, 0);
        repeat (5) step(1, 0, 0, 10, 0);
        repeat (2) step(0, 0, 0, 10, 0);
        step(0, 1, 3, 4, 0);
        step(0, 0, 0, 4, 0);
        step(1, 1, 8, 4, 0);
        repeat (3) step(1, 0, 0, 4, 0);
        step(1, 1, 20, 4, 0);
        repeat (40) step(1, 0, 0, 4, 0);
        step(1, 1, 12, 4, 0);
        step(1, 1, 20, 4, 0);
        repeat (2) step(0, 0, 0, 3, 0);
        st_cnt = 0;
        step(1, 0, 0, 3, 0);
        repeat (63) step(1, 0, 0, 3, 0);
        chk("div20_ticks", st_cnt, 3);
        repeat (2) step(0, 0, 0, 15, 0);
        step(1, 0, 0, 15, 0);
        repeat (107) step(1, 0, 0, 15, 0);
        step(1, 0, 0, 15, 1);
        step(0, 0, 0, 2, 0);
        st_cnt = 0;
        step(1, 0, 0, 2, 0);
        repeat (2 * DEF_DIV + 4) step(1, 0, 0, 2, 0);
        chk("rstdiv_ticks", st_cnt, 2);
        repeat (2) step(0, 0, 0, 0, 0);
        step(0, 1, 5, 0, 0);
        step(0, 0, 0, 0, 0);
        fd_t = -1;
        step(1, 0, 0, 0, 0);
        repeat (12) step(1, 0, 0, 0, 0);
        chk("min_bits_done_t", fd_t, 9);
        repeat (2) step(0, 0, 0, 3, 0);
        step(1, 0, 0, 3, 0);
        repeat (14) step(1, 0, 0, 3, 0);
        fd_t = -1;
        step(0, 0, 0, 3, 0);
        chk("fall_on_last_done_t", fd_t, 14);
        repeat (2) step(0, 0, 0, 3, 0);
        cs = 1'b0;
        repeat (3000) begin
            if ($urandom_range(0, 39) == 0) cs = !cs;
            step(cs, $urandom_range(0, 24) == 0, int'($urandom_range(0, 24)), int'($urandom_range(0, 15)), 1'b0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/rx_bit_timer.md
RX_BIT_TIMER -- requirements
Module: rx_bit_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, giving the system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, giving the reset-time baud rate.
REQ-003 SHALL have parameter DIV_W, default 16, giving the divisor and counter width.
REQ-004 CLK  in  1  system clock; one clock domain only, all logic on rising edge.
REQ-005 Rst  in  1  reset, synchronous, active-high.
REQ-006 Count_Sig  in  1  frame enable from the RX front end; high means a frame is in progress.
REQ-007 Frame_Bits  in  4  total bit periods per frame, start and stop bits included; range 2..15.
REQ-008 Div_Load  in  1  one-cycle strobe requesting a divisor update.
REQ-009 Div_Val  in  DIV_W  new divisor value, in clocks per bit.
REQ-010 Sample_Tick  out  1  one-cycle pulse at mid-bit.
REQ-011 Bit_End  out  1  one-cycle pulse in the last clock of each bit period.
REQ-012 Bit_Idx  out  4  index of the current bit; 0 is the start bit.
REQ-013 Frame_Done  out  1  one-cycle pulse on the Bit_End of the final bit.
REQ-014 Busy  out  1  high while in RUN.
REQ-015 Div_Err  out  1  one-cycle pulse when a Div_Load request is rejected.

Function
REQ-016 SHALL implement a three-state FSM with states IDLE, RUN and HOLD.
REQ-017 IDLE->RUN SHALL occur on a rising edge of Count_Sig (current sample 1, previous registered sample 0); on entry Cnt=0 and Bit_Idx=0, and Frame_Bits is latched, with values <2 latched as 2.
REQ-018 In RUN, Cnt SHALL increment each clock and wrap from Div_Reg-1 to 0; on each wrap Bit_Idx increments.
REQ-019 Sample_Tick SHALL be high in RUN exactly when Cnt == Div_Reg>>1 (floor); it is a combinational decode of registered state.
REQ-020 Bit_End SHALL be high in RUN exactly when Cnt == Div_Reg-1.
REQ-021 When Bit_End is high and Bit_Idx == latched Frame_Bits-1, Frame_Done SHALL be high in that same cycle, and the next state is HOLD if Count_Sig=1, else IDLE.
REQ-022 HOLD SHALL transition to IDLE when Count_Sig=0, so that a held-high Count_Sig never retriggers a frame.
REQ-023 Count_Sig=0 in RUN SHALL abort the frame: next state IDLE, Cnt and Bit_Idx cleared, no Frame_Done; if abort and final Bit_End coincide, the Frame_Done pulse still occurs.
REQ-024 Div_Load in IDLE or HOLD with Div_Val >= 4 SHALL load Div_Reg on the next edge.
REQ-025 Div_Load in RUN, or with Div_Val < 4, SHALL leave Div_Reg unchanged and pulse Div_Err in the following cycle.
REQ-026 Div_Load coinciding with the IDLE->RUN transition SHALL be rejected (Div_Err), so a frame always starts with a stable divisor.
REQ-027 Bit_Idx SHALL be 0 outside RUN.
REQ-028 Sample_Tick, Bit_End, Frame_Done and Busy SHALL be 0 outside RUN.

Reset
REQ-029 Rst=1 SHALL force the state to IDLE, Cnt=0, Bit_Idx=0, the previous-sample register to 0, Div_Reg=CLK_HZ/BAUD (5208 at defaults), and Div_Err=0.
REQ-030 All outputs SHALL read 0 in the cycle after Rst.
REQ-031 Reset SHALL take priority over every other input, including mid-frame.

Structure
REQ-032 The FSM state encoding and the minimum divisor constant (4) SHALL live in the shared UART package, also used by the RX/TX top levels.
REQ-033 The divisor register and validation logic SHALL be one sub-module, rx_div_reg; the counter and FSM remain in rx_bit_timer.

Verification
REQ-034 Load Div_Val=10 in IDLE, Frame_Bits=10, raise Count_Sig and hold -> Sample_Tick at Cnt=5 of each bit (10 pulses), Bit_End at Cnt=9, Frame_Done exactly 100 cycles after RUN entry, then HOLD with no retrigger.
REQ-035 Drop Count_Sig during bit 3, Cnt=4 -> IDLE next cycle, no Frame_Done, Bit_Idx=0; re-raise -> new frame starts at Bit_Idx=0, Cnt=0.
REQ-036 Div_Load with Div_Val=3 in IDLE, then Div_Val=20 during RUN -> Div_Err pulse for each, divisor stays 10; Div_Val=20 in IDLE -> next frame Sample_Tick at Cnt=10.
REQ-037 Assert Rst at bit 5 of a frame -> all outputs 0 the next cycle, Div_Reg=5208, IDLE; the first frame after reset uses Sample_Tick at Cnt=2604.
REQ-038 Frame_Bits=0 and Div_Val=5 -> frame runs 2 bits (10 cycles), with Sample_Tick at Cnt=2.
REQ-039 Count_Sig falling on the final Bit_End cycle -> Frame_Done still pulses, then IDLE, not HOLD.
